// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared state encoding and default widths for the BRAM port arbiter
package bram_arb_pkg;

  localparam int AW_DEFAULT = 4;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester, response and BRAM port signals of the arbiter
interface bram_port_arbiter_if import bram_arb_pkg::*; #(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) ();

  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            bram_wea;
  logic [AW-1:0]   bram_addra;
  logic [DW-1:0]   bram_dina;
  logic [DW-1:0]   bram_douta;

  // Requesters plus the BRAM itself: everything surrounding the arbiter.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, bram_douta,
    input  req_ready, rsp_valid, rsp_rdata, bram_wea, bram_addra, bram_dina
  );

  // The arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, bram_douta,
    output req_ready, rsp_valid, rsp_rdata, bram_wea, bram_addra, bram_dina
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester winner select; round-robin when BRAM_ARB_ROUND_ROBIN_EN is defined
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  // 1 means requester 1 won the most recent accept.
  logic last_grant;

  // Pointer follows the winner of every accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

  // A lone requester always wins; a tie goes to whoever did not win last.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
`else
  // Fixed priority: requester 0 beats requester 1.
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, accept};
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one BRAM port between two requesters (BRAM_ARB_ROUND_ROBIN_EN selects round-robin)
module bram_port_arbiter import bram_arb_pkg::*; #(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  bram_port_arbiter_if.slave bus
);

  state_t        state;
  logic          op_we;
  logic          win;
  logic [1:0]    grant;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.req_ready = (state == IDLE && !reset) ? grant : 2'b00;
  assign accept        = |bus.req_ready;

  // Route the winning requester's payload toward the capture registers.
  always_comb begin
    sel_we    = bus.req_we[0];
    sel_addr  = bus.req_addr[0 +: AW];
    sel_wdata = bus.req_wdata[0 +: DW];
    if (grant[1]) begin
      sel_we    = bus.req_we[1];
      sel_addr  = bus.req_addr[AW +: AW];
      sel_wdata = bus.req_wdata[DW +: DW];
    end
  end

  // Transaction sequencer; every BRAM and response output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op_we          <= 1'b0;
      win            <= 1'b0;
      bus.bram_wea   <= 1'b0;
      bus.bram_addra <= '0;
      bus.bram_dina  <= '0;
      bus.rsp_valid  <= 2'b00;
      bus.rsp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= 2'b00;
          if (accept) begin
            op_we          <= sel_we;
            win            <= grant[1];
            bus.bram_wea   <= sel_we;
            bus.bram_addra <= sel_addr;
            bus.bram_dina  <= sel_wdata;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.bram_wea <= 1'b0;
          if (op_we) begin
            bus.rsp_valid <= win ? 2'b10 : 2'b01;
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          bus.rsp_rdata <= bus.bram_douta;
          bus.rsp_valid <= win ? 2'b10 : 2'b01;
          state         <= RESP;
        end
        RESP: begin
          bus.rsp_valid <= 2'b00;
          state         <= IDLE;
        end
        default: begin
          bus.bram_wea  <= 1'b0;
          bus.rsp_valid <= 2'b00;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
